// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the NN sample sequencer.
package nn_pkg;

  localparam int NUM_FEATURES = 62;
  localparam int DATA_W       = 8;
  localparam int NUM_SAMPLES  = 750;
  localparam int WAIT_CYCLES  = 302;
  localparam int FEAT_VEC_W   = NUM_FEATURES * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_NNRST,
    S_RUN,
    S_CMP,
    S_DONE
  } state_t;

endpackage

// File: rtl/nn_wait_timer.sv
// Loadable down-counter that bounds the inference wait; zero_o flags expiry.
module nn_wait_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/nn_sample_sequencer.sv
// Streams feature samples into the NN core, scores labels and counts hits.
// Optional macro NN_DONE_HANDSHAKE_EN adds nn_done early exit and timeout_cnt.
module nn_sample_sequencer #(
  parameter int NUM_FEATURES = 62,
  parameter int DATA_W       = 8,
  parameter int NUM_SAMPLES  = 750,
  parameter int ADDR_W       = 16,
  parameter int LBL_ADDR_W   = 10,
  parameter int WAIT_CYCLES  = 302,
  parameter int CNT_W        = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  output logic                           feat_rd,
  output logic [ADDR_W-1:0]              feat_addr,
  input  logic [DATA_W-1:0]              feat_rdata,
  output logic                           lbl_rd,
  output logic [LBL_ADDR_W-1:0]          lbl_addr,
  input  logic [DATA_W-1:0]              lbl_rdata,
  output logic [NUM_FEATURES*DATA_W-1:0] nn_data,
  output logic                           nn_rst,
  output logic                           nn_start,
  input  logic [DATA_W-1:0]              nn_label,
`ifdef NN_DONE_HANDSHAKE_EN
  input  logic                           nn_done,
  output logic [CNT_W-1:0]               timeout_cnt,
`endif
  output logic                           busy,
  output logic                           done,
  output logic [LBL_ADDR_W-1:0]          sample_idx,
  output logic [CNT_W-1:0]               num_correct
);

  import nn_pkg::*;

  localparam int JW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int TW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int VW = NUM_FEATURES * DATA_W;

  state_t                  state_q, state_d;
  logic [JW-1:0]           j_q, j_d, rd_idx_q;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [LBL_ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        correct_q, correct_d;
  logic [DATA_W-1:0]       golden_q;
  logic [VW-1:0]           data_q;
  logic                    rd_vld_q, lbl_vld_q;
  logic                    tmr_zero, run_exit, hit, last_j, last_sample, start_ok;

  assign last_j      = (j_q == JW'(NUM_FEATURES - 1));
  assign last_sample = (idx_q == LBL_ADDR_W'(NUM_SAMPLES - 1));
  assign start_ok    = ((state_q == S_IDLE) || (state_q == S_DONE)) && go;

  // The timer is reloaded with WAIT_CYCLES-1 so RUN lasts exactly WAIT_CYCLES cycles.
  nn_wait_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_NNRST),
    .load_val_i (TW'(WAIT_CYCLES - 1)),
    .en_i       (state_q == S_RUN),
    .zero_o     (tmr_zero)
  );

`ifdef NN_DONE_HANDSHAKE_EN
  logic             tmo_flag_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  assign run_exit = nn_done | tmr_zero;
  assign hit      = (nn_label == golden_q) && !tmo_flag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      if ((state_q == S_RUN) && run_exit) tmo_flag_q <= !nn_done;
      if (start_ok) begin
        tmo_cnt_q <= '0;
      end else if ((state_q == S_CMP) && tmo_flag_q && (tmo_cnt_q != '1)) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign timeout_cnt = tmo_cnt_q;
`else
  assign run_exit = tmr_zero;
  assign hit      = (nn_label == golden_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_FETCH;
      S_FETCH:        if (last_j) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_NNRST;
      S_NNRST:        state_d = S_RUN;
      S_RUN:          if (run_exit) state_d = S_CMP;
      S_CMP:          state_d = last_sample ? S_DONE : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Base address advances by addition so no multiplier is needed.
  always_comb begin
    j_d       = j_q;
    base_d    = base_q;
    idx_d     = idx_q;
    correct_d = correct_q;
    if (start_ok) begin
      j_d       = '0;
      base_d    = '0;
      idx_d     = '0;
      correct_d = '0;
    end else if (state_q == S_FETCH) begin
      j_d = last_j ? '0 : j_q + 1'b1;
    end else if (state_q == S_CMP) begin
      if (hit && (correct_q != '1)) correct_d = correct_q + 1'b1;
      if (!last_sample) begin
        idx_d  = idx_q + 1'b1;
        base_d = base_q + ADDR_W'(NUM_FEATURES);
      end
    end
  end

  // Read data returns one cycle late, so the byte index is delayed to match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_q       <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      correct_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      lbl_vld_q <= 1'b0;
      golden_q  <= '0;
      data_q    <= '0;
    end else begin
      j_q       <= j_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      correct_q <= correct_d;
      rd_vld_q  <= feat_rd;
      rd_idx_q  <= j_q;
      lbl_vld_q <= lbl_rd;
      if (lbl_vld_q) golden_q <= lbl_rdata;
      if (rd_vld_q) data_q[int'(rd_idx_q)*DATA_W +: DATA_W] <= feat_rdata;
    end
  end

  always_comb begin
    feat_rd   = (state_q == S_FETCH);
    feat_addr = feat_rd ? (base_q + ADDR_W'(j_q)) : '0;
    lbl_rd    = feat_rd && (j_q == '0);
    lbl_addr  = idx_q;
    nn_rst    = (state_q == S_NNRST);
    nn_start  = (state_q == S_NNRST) || (state_q == S_RUN);
    busy      = !((state_q == S_IDLE) || (state_q == S_DONE));
    done      = (state_q == S_DONE);
  end

  assign nn_data     = data_q;
  assign sample_idx  = idx_q;
  assign num_correct = correct_q;

endmodule

// File: doc/nn_sample_sequencer.md
Name: nn_sample_sequencer

Overview:
- Hardware initiator for the NN inference core; replaces bench-driven stimulus.
- Streams test samples byte-by-byte from a feature memory and assembles the flat feature vector.
- Pulses the NN reset/start, waits for inference, compares the NN label against a golden-label memory, and accumulates the correct count over the whole sample set.

Parameters:
- NUM_FEATURES, 62: bytes per sample.
- DATA_W, 8: feature and label width.
- NUM_SAMPLES, 750: samples per run.
- ADDR_W, 16: feature memory address width; must satisfy 2^ADDR_W >= NUM_SAMPLES*NUM_FEATURES.
- LBL_ADDR_W, 10: label memory address width.
- WAIT_CYCLES, 302: NN clock cycles allowed per inference.
- CNT_W, 32: correct-counter width.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- go, in, 1: start a run; sampled in IDLE and DONE only.
- feat_rd, out, 1: feature memory read strobe.
- feat_addr, out, ADDR_W: feature memory address.
- feat_rdata, in, DATA_W: feature data, valid exactly 1 cycle after feat_rd.
- lbl_rd, out, 1: label memory read strobe.
- lbl_addr, out, LBL_ADDR_W: label memory address.
- lbl_rdata, in, DATA_W: golden label, valid 1 cycle after lbl_rd.
- nn_data, out, NUM_FEATURES*DATA_W: feature vector; byte j occupies [j*8 +: 8].
- nn_rst, out, 1: synchronous active-high reset pulse to NN.
- nn_start, out, 1: NN start level.
- nn_label, in, DATA_W: NN result.
- busy, out, 1: high from go acceptance until DONE.
- done, out, 1: high in DONE.
- sample_idx, out, LBL_ADDR_W: index of the current sample.
- num_correct, out, CNT_W: running correct count.

Behaviour:
- Reset values: all outputs 0.
  - Reset state is IDLE.
  - Reset mid-run aborts immediately with no partial state retained.
- States: IDLE, FETCH, DRAIN, NNRST, RUN, CMP, DONE.
- IDLE:
  - go=1 moves to FETCH.
  - Clears sample_idx, num_correct and base address.
  - Sets busy.
- FETCH: lasts NUM_FEATURES cycles, j=0..NUM_FEATURES-1.
  - feat_rd=1 and feat_addr=base+j every cycle.
  - On the first FETCH cycle, lbl_rd=1 and lbl_addr=sample_idx; the label is captured into golden_q the next cycle.
  - The feature byte returning at cycle j+1 is written to nn_data byte j, using a 1-cycle-delayed index.
- DRAIN: one cycle.
  - Captures the last byte.
  - feat_rd=0.
- NNRST: one cycle.
  - nn_rst=1.
  - nn_start is asserted here and held through RUN.
- RUN:
  - Wait counter loads WAIT_CYCLES and decrements each cycle.
  - Moves to CMP when the counter reaches 0.
  - nn_data is held stable throughout.
- CMP: one cycle.
  - If nn_label == golden_q, num_correct increments, saturating at all-ones.
  - nn_start drops.
  - If sample_idx == NUM_SAMPLES-1, go to DONE.
  - Otherwise: sample_idx increments, base increments by NUM_FEATURES (no multiplier), then go to FETCH.
- DONE:
  - done=1, busy=0.
  - num_correct is held.
  - go=1 restarts exactly as from IDLE: clears the count and sets done=0 next cycle.
- go is ignored while busy.
- Per-sample latency: NUM_FEATURES + 1 + 1 + WAIT_CYCLES + 1 cycles. Default 367.
- Boundaries:
  - NUM_SAMPLES=1: DONE is reached after the first CMP.
  - The last sample's address is base = (NUM_SAMPLES-1)*NUM_FEATURES, with no wrap.

Optional Feature:
- Macro NN_DONE_HANDSHAKE_EN.
- When defined:
  - Adds input nn_done (1 bit).
  - RUN exits to CMP on the first cycle nn_done=1.
  - WAIT_CYCLES acts as a timeout: if the counter expires first, the sample is scored incorrect without comparison.
  - Adds output timeout_cnt (CNT_W), the number of timed-out samples; reset 0, cleared on go.
- When undefined: fixed-latency wait only; neither port exists.

Decomposition:
- Shared package nn_pkg:
  - Constants NUM_FEATURES, DATA_W, NUM_SAMPLES, WAIT_CYCLES.
  - State enum typedef.
  - Feature-vector width constant.
- One sub-module, nn_wait_timer:
  - Loadable down-counter with load, enable and zero flag.
  - Used for RUN.

Test Plan:
- Reset: assert rst=0 mid-FETCH of sample 3 -> next cycle state IDLE, num_correct=0, busy=0, nn_data=0.
- Vector assembly: feature memory holds value (addr mod 256); sample 0 -> at NNRST, nn_data byte j = j for j=0..61; sample 1 -> byte j = 62+j.
- Scoring: NN model returns lbl_rdata for even samples and lbl_rdata+1 for odd samples; NUM_SAMPLES=750 -> done=1 with num_correct=375.
- Timing: measure go to done with default parameters -> exactly 1 + 750*367 cycles (±1 for the IDLE transition, as defined by implementation and recorded); nn_rst is high exactly 750 single cycles.
- Restart: go asserted in DONE -> num_correct cleared, sample_idx=0, second run gives an identical count; go pulses while busy have no effect.
- NN_DONE_HANDSHAKE_EN: nn_done raised 10 cycles into RUN -> CMP occurs at RUN cycle 10; nn_done never raised on sample 5 -> timeout_cnt=1 and sample 5 is not counted as correct.
